sprite_array_src: RTL and testbench

SPRITE_ARRAY_SRC -- requirements
Module: sprite_array_src

---
 rtl/sprite_pkg.sv | 62 ++++++
 rtl/sprite_array_src_if.sv | 29 ++
 rtl/sprite_ram.sv | 27 ++
 rtl/sprite_array_src.sv | 188 ++++++++++++++++++
 tb/tb_sprite_array_src.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite array: slot record, sprite-table
// word layout, palette colours and pattern geometry.
package sprite_pkg;

    localparam int H_SIZE = 32;
    localparam int V_SIZE = 32;

    localparam int X0_LSB   = 0;
    localparam int Y0_LSB   = 11;
    localparam int COL_LSB  = 22;
    localparam int ID_LSB   = 24;
    localparam int EN_BIT   = 26;
    localparam int ANIM_BIT = 27;
    localparam int SLOT_W   = 28;

    localparam logic [11:0] PAL_CODE1 = 12'hff0;
    localparam logic [11:0] PAL_CODE3 = 12'hf1f;
    localparam logic [11:0] PAL_COL0  = 12'h070;
    localparam logic [11:0] PAL_COL1  = 12'hf00;
    localparam logic [11:0] PAL_COL2  = 12'hfa0;
    localparam logic [11:0] PAL_COL3  = 12'h088;

    typedef struct packed {
        logic        anim_en;
        logic        en;
        logic [1:0]  id;
        logic [1:0]  col;
        logic [10:0] y0;
        logic [10:0] x0;
    } slot_t;

    function automatic slot_t slot_decode(input logic [SLOT_W-1:0] w);
        slot_t s;
        s.x0      = w[X0_LSB +: 11];
        s.y0      = w[Y0_LSB +: 11];
        s.col     = w[COL_LSB +: 2];
        s.id      = w[ID_LSB +: 2];
        s.en      = w[EN_BIT];
        s.anim_en = w[ANIM_BIT];
        return s;
    endfunction

    // Code 0 is transparent and resolved to the key colour by the caller.
    function automatic logic [11:0] pal_lookup(input logic [1:0] code, input logic [1:0] col);
        logic [11:0] c;
        case (code)
            2'd1: c = PAL_CODE1;
            2'd2: begin
                case (col)
                    2'd0:    c = PAL_COL0;
                    2'd1:    c = PAL_COL1;
                    2'd2:    c = PAL_COL2;
                    default: c = PAL_COL3;
                endcase
            end
            2'd3:    c = PAL_CODE3;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_array_src_if.sv
// Scan, sprite-table, pattern-RAM and pixel-output signals of sprite_array_src.
interface sprite_array_src_if #(
    parameter int CD   = 12,
    parameter int ADDR = 10
);
    logic [10:0]     x;
    logic [10:0]     y;
    logic            frame_tick;
    logic            reg_we;
    logic [4:0]      reg_addr;
    logic [31:0]     reg_wdata;
    logic            ram_we;
    logic [ADDR-1:0] ram_addr_w;
    logic [1:0]      ram_pixel_in;
    logic [CD-1:0]   sprite_rgb;
    logic            collision;

    modport master (
        output x, y, frame_tick, reg_we, reg_addr, reg_wdata,
        output ram_we, ram_addr_w, ram_pixel_in,
        input  sprite_rgb, collision
    );

    modport slave (
        input  x, y, frame_tick, reg_we, reg_addr, reg_wdata,
        input  ram_we, ram_addr_w, ram_pixel_in,
        output sprite_rgb, collision
    );
endinterface

// File: rtl/sprite_ram.sv
// Pattern RAM: 2-bit pixels, synchronous write, NRD synchronous read ports
// returning the pre-write data on a same-address collision. Not reset.
module sprite_ram #(
    parameter int ADDR = 10,
    parameter int NRD  = 1
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [ADDR-1:0] waddr_i,
    input  logic [1:0]      wdata_i,
    input  logic [ADDR-1:0] raddr_i [NRD],
    output logic [1:0]      rdata_o [NRD]
);
    logic [1:0] mem_q   [2**ADDR];
    logic [1:0] rdata_q [NRD];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        for (int unsigned i = 0; i < NRD; i++) begin
            rdata_q[i] <= mem_q[raddr_i[i]];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/sprite_array_src.sv
// Sprite compositor: slot table, hit/priority, 2-stage pixel pipeline and
// frame-based animation. Define SPR_COLLISION_EN to build overlap detection.
module sprite_array_src
    import sprite_pkg::*;
#(
    parameter int            N_SPR     = 20,
    parameter int            CD        = 12,
    parameter int            ADDR      = 10,
    parameter logic [CD-1:0] KEY_COLOR = '0,
    parameter int            ANIM_DIV  = 8
) (
    input  logic              clk,
    input  logic              reset,
    sprite_array_src_if.slave bus
);
    localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int WW = (N_SPR > 1) ? $clog2(N_SPR) : 1;
`ifdef SPR_COLLISION_EN
    localparam int NRD = N_SPR;
`else
    localparam int NRD = 1;
`endif

    slot_t              slots_q [N_SPR];
    logic [AW-1:0]      anim_cnt_q;
    logic [1:0]         phase_q;
    logic signed [11:0] dx [N_SPR];
    logic signed [11:0] dy [N_SPR];
    logic [1:0]         eff_id [N_SPR];
    logic [ADDR-1:0]    slot_addr [N_SPR];
    logic [N_SPR-1:0]   hit;
    logic               hit_any;
    logic [WW-1:0]      win;
    logic [ADDR-1:0]    raddr [NRD];
    logic [1:0]         rdata [NRD];
    logic               hit_any_q;
    logic [1:0]         col_q;
    logic [1:0]         code;
    logic [CD-1:0]      rgb_d;
    logic [CD-1:0]      rgb_q;
`ifdef SPR_COLLISION_EN
    logic [N_SPR-1:0]   hit_q;
    logic [WW-1:0]      win_q;
    logic               seen;
    logic               det;
    logic               sticky_q;
    logic               coll_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SPR; i++) begin
                slots_q[i] <= '0;
            end
        end else if (bus.reg_we && ({27'd0, bus.reg_addr} < 32'(N_SPR))) begin
            slots_q[bus.reg_addr] <= slot_decode(bus.reg_wdata[SLOT_W-1:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anim_cnt_q <= '0;
            phase_q    <= '0;
        end else if (bus.frame_tick) begin
            if (32'(anim_cnt_q) == 32'(ANIM_DIV - 1)) begin
                anim_cnt_q <= '0;
                phase_q    <= phase_q + 2'd1;
            end else begin
                anim_cnt_q <= anim_cnt_q + AW'(1);
            end
        end
    end

    // 12-bit signed offsets keep origins near 2047 from aliasing onto column/row 0.
    always_comb begin
        for (int unsigned i = 0; i < N_SPR; i++) begin
            dx[i]        = $signed({1'b0, bus.x}) - $signed({1'b0, slots_q[i].x0});
            dy[i]        = $signed({1'b0, bus.y}) - $signed({1'b0, slots_q[i].y0});
            hit[i]       = slots_q[i].en
                         && (dx[i] >= 12'sd0) && (dx[i] < $signed(12'(H_SIZE)))
                         && (dy[i] >= 12'sd0) && (dy[i] < $signed(12'(V_SIZE)));
            eff_id[i]    = slots_q[i].anim_en ? (slots_q[i].id + phase_q) : slots_q[i].id;
            slot_addr[i] = ADDR'({eff_id[i], dy[i][4:0], dx[i][4:0]});
        end
    end

    always_comb begin
        win     = '0;
        hit_any = 1'b0;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            if (hit[i] && !hit_any) begin
                win     = WW'(i);
                hit_any = 1'b1;
            end
        end
    end

`ifdef SPR_COLLISION_EN
    assign raddr = slot_addr;
`else
    assign raddr[0] = slot_addr[win];
`endif

    // The RAM's read register forms the stage-1 address/data register.
    sprite_ram #(
        .ADDR (ADDR),
        .NRD  (NRD)
    ) u_ram (
        .clk     (clk),
        .we_i    (bus.ram_we),
        .waddr_i (bus.ram_addr_w),
        .wdata_i (bus.ram_pixel_in),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_any_q <= 1'b0;
            col_q     <= '0;
`ifdef SPR_COLLISION_EN
            hit_q     <= '0;
            win_q     <= '0;
`endif
        end else begin
            hit_any_q <= hit_any;
            col_q     <= slots_q[win].col;
`ifdef SPR_COLLISION_EN
            hit_q     <= hit;
            win_q     <= win;
`endif
        end
    end

`ifdef SPR_COLLISION_EN
    assign code = rdata[win_q];
`else
    assign code = rdata[0];
`endif

    always_comb begin
        rgb_d = KEY_COLOR;
        if (hit_any_q && (code != 2'd0)) begin
            rgb_d = CD'(pal_lookup(code, col_q));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= KEY_COLOR;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.sprite_rgb = rgb_q;

`ifdef SPR_COLLISION_EN
    always_comb begin
        seen = 1'b0;
        det  = 1'b0;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            if (hit_q[i] && (rdata[i] != 2'd0)) begin
                if (seen) begin
                    det = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
            coll_q   <= 1'b0;
        end else if (bus.frame_tick) begin
            coll_q   <= sticky_q | det;
            sticky_q <= 1'b0;
        end else if (det) begin
            sticky_q <= 1'b1;
        end
    end

    assign bus.collision = coll_q;
`else
    assign bus.collision = 1'b0;
`endif
endmodule

// File: tb/tb_sprite_array_src.sv
// Scoreboard bench for sprite_array_src: pixel expectations are queued at
// issue time and checked by a monitor two cycles later.
module tb_sprite_array_src;
    localparam int CD   = 12;
    localparam int ADDR = 12;
`ifdef SPR_COLLISION_EN
    localparam logic COLL_ON = 1'b1;
`else
    localparam logic COLL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_array_src_if #(.CD(CD), .ADDR(ADDR)) bus ();

    sprite_array_src #(
        .N_SPR     (20),
        .CD        (CD),
        .ADDR      (ADDR),
        .KEY_COLOR (12'h000),
        .ANIM_DIV  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q  [$];
    string       name_q [$];
    bit chk_in = 1'b0;
    bit t1 = 1'b0;
    bit t2 = 1'b0;
    logic [11:0] mon_e;
    string       mon_n;

    always @(posedge clk) begin
        t1 <= chk_in;
        t2 <= t1;
    end

    always @(negedge clk) begin
        if (t2) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: sprite_rgb=%h with no expectation queued", bus.sprite_rgb);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (bus.sprite_rgb !== mon_e) begin
                    bad++;
                    $display("FAIL %s: sprite_rgb=%h expected=%h", mon_n, bus.sprite_rgb, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input int x0, input int y0, input int col,
                                       input int id, input int en, input int an);
        return {4'b0, 1'(an), 1'(en), 2'(id), 2'(col), 11'(y0), 11'(x0)};
    endfunction

    function automatic logic [11:0] ra(input int id, input int px, input int py);
        return {2'(id), 5'(py), 5'(px)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string n, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", n, act, exp);
        end
    endtask

    // Strobes set by the caller before pix() share its clock edge.
    task automatic pix(input int px, input int py, input logic [11:0] e, input string n);
        bus.x  = 11'(px);
        bus.y  = 11'(py);
        chk_in = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        tick();
        chk_in         = 1'b0;
        bus.x          = '0;
        bus.y          = '0;
        bus.reg_we     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic wr_slot(input int a, input logic [31:0] w);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 5'(a);
        bus.reg_wdata = w;
        tick();
        bus.reg_we = 1'b0;
    endtask

    task automatic wr_ram(input int id, input int px, input int py, input logic [1:0] d);
        bus.ram_we       = 1'b1;
        bus.ram_addr_w   = ra(id, px, py);
        bus.ram_pixel_in = d;
        tick();
        bus.ram_we = 1'b0;
    endtask

    task automatic ftick();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus.x            = '0;
        bus.y            = '0;
        bus.frame_tick   = 1'b0;
        bus.reg_we       = 1'b0;
        bus.reg_addr     = '0;
        bus.reg_wdata    = '0;
        bus.ram_we       = 1'b0;
        bus.ram_addr_w   = '0;
        bus.ram_pixel_in = '0;
        repeat (3) tick();
        check("rgb_in_reset", bus.sprite_rgb, 12'h000);
        check("coll_in_reset", {11'b0, bus.collision}, 12'h000);
        reset = 1'b0;
        tick();

        wr_ram(1, 3, 2, 2'd2);
        wr_ram(1, 4, 2, 2'd1);
        wr_ram(1, 5, 2, 2'd3);
        wr_ram(1, 0, 0, 2'd0);
        wr_ram(1, 31, 31, 2'd1);
        wr_ram(1, 13, 2, 2'd1);
        wr_ram(1, 3, 13, 2'd1);
        wr_ram(2, 1, 1, 2'd2);
        wr_ram(0, 0, 0, 2'd1);
        wr_ram(2, 0, 0, 2'd3);
        wr_ram(3, 0, 0, 2'd2);

        wr_slot(0, mk(100, 50, 1, 1, 1, 0));
        wr_slot(1, mk(300, 50, 2, 1, 1, 0));
        wr_slot(3, mk(400, 50, 3, 1, 1, 0));
        wr_slot(4, mk(500, 50, 0, 1, 1, 0));

        pix(103, 52, 12'hf00, "basic_code2_col01");
        pix(104, 52, 12'hff0, "code1");
        pix(105, 52, 12'hf1f, "code3");
        pix(100, 50, 12'h000, "code0_key");
        pix(99, 52, 12'h000, "left_of_sprite");
        pix(131, 81, 12'hff0, "corner_31_31");
        pix(132, 52, 12'h000, "right_edge_dx32");
        pix(103, 82, 12'h000, "bottom_edge_dy32");
        pix(303, 52, 12'hfa0, "col10");
        pix(403, 52, 12'h088, "col11");
        pix(503, 52, 12'h070, "col00");

        // Table write colliding with a hit on the same slot.
        bus.reg_we    = 1'b1;
        bus.reg_addr  = 5'd0;
        bus.reg_wdata = mk(100, 50, 2, 1, 1, 0);
        pix(103, 52, 12'hf00, "regwr_same_cycle_old");
        pix(103, 52, 12'hfa0, "regwr_next_cycle_new");

        // RAM write colliding with a read of the same pixel.
        bus.ram_we       = 1'b1;
        bus.ram_addr_w   = ra(1, 3, 2);
        bus.ram_pixel_in = 2'd3;
        pix(103, 52, 12'hfa0, "ram_rw_old");
        pix(103, 52, 12'hf1f, "ram_rw_new");

        wr_slot(0, mk(2040, 50, 1, 1, 1, 0));
        pix(5, 52, 12'h000, "no_wrap_x");
        pix(2043, 52, 12'hf1f, "hit_near_2047");
        wr_slot(0, mk(100, 2040, 1, 1, 1, 0));
        pix(103, 5, 12'h000, "no_wrap_y");

        wr_slot(25, mk(700, 50, 1, 1, 1, 0));
        pix(703, 52, 12'h000, "ignored_addr25");

        wr_slot(2, mk(200, 200, 1, 2, 1, 0));
        wr_slot(5, mk(200, 200, 2, 2, 1, 0));
        pix(201, 201, 12'hf00, "priority_slot2");
        tick();
        tick();
        check("coll_before_tick", {11'b0, bus.collision}, 12'h000);
        ftick();
        check("coll_after_tick", {11'b0, bus.collision}, {11'b0, COLL_ON});
        wr_slot(5, mk(200, 200, 2, 2, 0, 0));
        check("coll_held_in_frame", {11'b0, bus.collision}, {11'b0, COLL_ON});
        pix(201, 201, 12'hf00, "slot2_alone");
        tick();
        tick();
        ftick();
        check("coll_cleared", {11'b0, bus.collision}, 12'h000);

        wr_slot(5, mk(200, 200, 2, 2, 1, 0));
        bus.x = 11'd201;
        bus.y = 11'd201;
        repeat (3) tick();
        ftick();
        check("rgb_pre_reset", bus.sprite_rgb, 12'hf00);
        check("coll_pre_reset", {11'b0, bus.collision}, {11'b0, COLL_ON});
        reset = 1'b1;
        #1;
        check("rgb_reset_mid_line", bus.sprite_rgb, 12'h000);
        check("coll_reset_mid_line", {11'b0, bus.collision}, 12'h000);
        tick();
        tick();
        check("rgb_held_in_reset", bus.sprite_rgb, 12'h000);
        reset = 1'b0;
        bus.x = '0;
        bus.y = '0;
        tick();
        pix(201, 201, 12'h000, "slots_cleared_by_reset");

        wr_slot(6, mk(600, 50, 1, 3, 1, 1));
        wr_slot(7, mk(650, 50, 1, 3, 1, 0));
        pix(600, 50, 12'hf00, "anim_phase0_ram_kept");
        repeat (7) ftick();
        pix(600, 50, 12'hf00, "anim_7_ticks_id3");
        ftick();
        pix(600, 50, 12'hff0, "anim_8_ticks_id0");
        pix(650, 50, 12'hf00, "static_slot_id3");
        repeat (8) ftick();
        pix(600, 50, 12'h000, "anim_16_ticks_id1");
        repeat (8) ftick();
        pix(600, 50, 12'hf1f, "anim_24_ticks_id2");
        repeat (8) ftick();
        pix(600, 50, 12'hf00, "anim_32_ticks_id3");

        repeat (4) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
